// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer driving the shared core ALU.
// Ports: clk/rst/flush; in_* request (valid/ready); alu_* ALU borrow; out_* result (valid/ready).
module mdu_sequencer #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic            alu_own,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] alu_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state, nxt;
    logic [2:0]      f3;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] opa, opb;
    logic            n1, n2;
    // acc = product high half / partial remainder
    // lo  = product low half (multiplier) / quotient (dividend)
    // opr = multiplicand / divisor magnitude
    logic [XLEN-1:0] acc, lo, opr;
    logic [4:0]      cnt;
    logic [XLEN-1:0] res;

    logic            is_div;
    logic [XLEN-1:0] ma, mb;
    logic            div0, ovf, special;
    logic [XLEN-1:0] spec_res;
    logic [XLEN-1:0] sh_rem;
    logic            msb, carry, take;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s, fix_res;
    logic            acc_sign1, acc_sign2;

    assign is_div = f3[2];
    assign ma     = n1 ? -opa : opa;
    assign mb     = n2 ? -opb : opb;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign div0     = (opb == '0);
    assign ovf      = !f3[0] && (opa == MIN_NEG) && (opb == '1);
    assign special  = is_div && (div0 || ovf);
    assign spec_res = div0 ? (f3[1] ? opa : '1)
                           : (f3[1] ? '0  : MIN_NEG);

    assign sh_rem = {acc[XLEN-2:0], lo[XLEN-1]};
    assign msb    = acc[XLEN-1];
    assign carry  = (alu_op < acc);
    assign take   = msb || (sh_rem >= opr);

    assign prod    = {acc, lo};
    assign prod_s  = (n1 ^ n2) ? -prod : prod;
    assign quo_s   = (n1 ^ n2) ? -lo : lo;
    assign rem_s   = n1 ? -acc : acc;

    always_comb begin
        fix_res = '0;
        unique case (f3)
            3'd0:    fix_res = prod_s[XLEN-1:0];
            3'd1,
            3'd2,
            3'd3:    fix_res = prod_s[2*XLEN-1:XLEN];
            3'd4,
            3'd5:    fix_res = quo_s;
            default: fix_res = rem_s;
        endcase
    end

    // Operand signedness: MULH/DIV/REM both, MULHSU rs1 only.
    always_comb begin
        acc_sign1 = 1'b0;
        acc_sign2 = 1'b0;
        unique case (in_funct3)
            3'd1, 3'd4, 3'd6: begin
                acc_sign1 = in_rs1[XLEN-1];
                acc_sign2 = in_rs2[XLEN-1];
            end
            3'd2:    acc_sign1 = in_rs1[XLEN-1];
            default: ;
        endcase
    end

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        alu_own   = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_ctrl  = ALU_ADD;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = PREP;
            end
            PREP: nxt = special ? DONE : ITER;
            ITER: begin
                alu_own  = 1'b1;
                alu_a    = is_div ? sh_rem : acc;
                alu_b    = opr;
                alu_ctrl = is_div ? ALU_SUB : ALU_ADD;
                if (cnt == 5'(ITERS - 1)) nxt = FIX;
            end
            FIX: nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
        if (flush) nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            f3    <= '0;
            rd_q  <= '0;
            opa   <= '0;
            opb   <= '0;
            n1    <= 1'b0;
            n2    <= 1'b0;
            acc   <= '0;
            lo    <= '0;
            opr   <= '0;
            cnt   <= '0;
            res   <= '0;
        end else begin
            state <= nxt;
            if (!flush) begin
                unique case (state)
                    IDLE: if (in_valid) begin
                        f3   <= in_funct3;
                        rd_q <= in_rd;
                        opa  <= in_rs1;
                        opb  <= in_rs2;
                        n1   <= acc_sign1;
                        n2   <= acc_sign2;
                    end
                    PREP: begin
                        acc <= '0;
                        cnt <= '0;
                        lo  <= is_div ? ma : mb;
                        opr <= is_div ? mb : ma;
                        if (special) res <= spec_res;
                    end
                    ITER: begin
                        cnt <= cnt + 5'd1;
                        if (is_div) begin
                            if (take) begin
                                acc <= alu_op;
                                lo  <= {lo[XLEN-2:0], 1'b1};
                            end else begin
                                acc <= sh_rem;
                                lo  <= {lo[XLEN-2:0], 1'b0};
                            end
                        end else if (lo[0]) begin
                            acc <= {carry, alu_op[XLEN-1:1]};
                            lo  <= {alu_op[0], lo[XLEN-1:1]};
                        end else begin
                            acc <= {1'b0, acc[XLEN-1:1]};
                            lo  <= {acc[0], lo[XLEN-1:1]};
                        end
                    end
                    FIX: res <= fix_res;
                    default: ;
                endcase
            end
        end
    end

    assign out_data = res;
    assign out_rd   = rd_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with a behavioural core ALU.
// Vector table for the arithmetic cases plus hand sequences for stall, flush and reset.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic [4:0]  in_rd = '0;
    logic        alu_own;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_op;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [4:0]  out_rd;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Core ALU stand-in: ADD / SUB only.
    assign alu_op = (alu_ctrl == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

    mdu_sequencer dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .alu_own(alu_own), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ctrl(alu_ctrl), .alu_op(alu_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and return #1 after the accepting edge (state PREP).
    task automatic accept(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        int n;
        in_funct3 = f3;
        in_rs1    = a;
        in_rs2    = b;
        in_rd     = rd;
        in_valid  = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        step();
        in_valid = 1'b0;
    endtask

    // Run to out_valid; report latency, ALU-own cycles and ALU bus violations.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          output int lat, output int own, output int bad);
        logic [3:0] ectl;
        ectl = {3'b000, f3[2]};
        accept(f3, a, b, rd);
        lat = 1;
        own = 0;
        bad = 0;
        while (!out_valid && lat < 100) begin
            if (alu_own) begin
                own++;
                if (alu_ctrl !== ectl) bad++;
            end else if ((alu_a | alu_b) != 0 || alu_ctrl != 4'b0000) begin
                bad++;
            end
            step();
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid got 0 required 1");
        end
    endtask

    initial begin
        int lat, own, bad, stable_bad;
        logic [31:0] d0;

        vecs[0]  = '{3'd0, 32'd7,        32'd6,        5'd1,  32'd42,       35};
        vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'd5,        5'd2,  32'hFFFFFFF1, 35};
        vecs[2]  = '{3'd1, 32'h80000000, 32'h80000000, 5'd3,  32'h40000000, 35};
        vecs[3]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4,  32'hFFFFFFFE, 35};
        vecs[4]  = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5,  32'hFFFFFFFF, 35};
        vecs[5]  = '{3'd4, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFD, 35};
        vecs[6]  = '{3'd6, 32'hFFFFFFF9, 32'd2,        5'd7,  32'hFFFFFFFF, 35};
        vecs[7]  = '{3'd5, 32'd100,      32'd7,        5'd8,  32'd14,       35};
        vecs[8]  = '{3'd7, 32'd100,      32'd7,        5'd9,  32'd2,        35};
        vecs[9]  = '{3'd4, 32'd5,        32'd0,        5'd10, 32'hFFFFFFFF, 2};
        vecs[10] = '{3'd6, 32'd5,        32'd0,        5'd11, 32'd5,        2};
        vecs[11] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 2};
        vecs[12] = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'd0,        2};
        vecs[13] = '{3'd6, 32'd7,        32'hFFFFFFFE, 5'd14, 32'd1,        35};
        vecs[14] = '{3'd7, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 35};
        vecs[15] = '{3'd6, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFB, 2};

        repeat (3) step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_own", 32'(alu_own), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_bus", alu_a | alu_b | 32'(alu_ctrl), 32'd0);
        chk("rst_out", out_data | 32'(out_rd), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].rd, lat, own, bad);
            chk($sformatf("v%0d_data", i), out_data, vecs[i].exp);
            chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
            chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("v%0d_own", i), 32'(own),
                (vecs[i].lat == 35) ? 32'd32 : 32'd0);
            chk($sformatf("v%0d_alubus", i), 32'(bad), 32'd0);
            step();
            chk($sformatf("v%0d_idle", i), {30'd0, in_ready, out_valid}, 32'd2);
        end

        // Writeback stall: result and tag must hold for 10 cycles.
        out_ready = 1'b0;
        run_op(3'd0, 32'd11, 32'd13, 5'd9, lat, own, bad);
        chk("stall_data", out_data, 32'd143);
        d0 = out_data;
        stable_bad = 0;
        for (int k = 0; k < 10; k++) begin
            if (!out_valid || in_ready || out_data !== d0 || out_rd !== 5'd9)
                stable_bad++;
            step();
        end
        chk("stall_stable", 32'(stable_bad), 32'd0);
        out_ready = 1'b1;
        step();
        chk("stall_release", {30'd0, in_ready, out_valid}, 32'd2);

        // Flush during ITER count 10.
        accept(3'd0, 32'd21, 32'd2, 5'd20);
        repeat (11) step();
        chk("pre_flush_own", 32'(alu_own), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_idle", {29'd0, in_ready, alu_own, out_valid}, 32'd4);
        stable_bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid || alu_own) stable_bad++;
            step();
        end
        chk("flush_no_result", 32'(stable_bad), 32'd0);
        run_op(3'd0, 32'd3, 32'd3, 5'd17, lat, own, bad);
        chk("post_flush_data", out_data, 32'd9);
        chk("post_flush_rd", 32'(out_rd), 32'd17);
        chk("post_flush_lat", 32'(lat), 32'd35);
        step();

        // Flush beats a simultaneous accept.
        in_funct3 = 3'd0;
        in_rs1    = 32'd2;
        in_rs2    = 32'd2;
        in_valid  = 1'b1;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk("flush_vs_accept", {30'd0, in_ready, alu_own}, 32'd2);

        // Reset during ITER count 20.
        accept(3'd5, 32'd1000, 32'd3, 5'd22);
        repeat (21) step();
        chk("pre_rst_own", 32'(alu_own), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_ctrl", {28'd0, in_ready, alu_own, out_valid, 1'b0}, 32'd8);
        chk("midrst_bus", alu_a | alu_b | 32'(alu_ctrl), 32'd0);
        chk("midrst_out", out_data | 32'(out_rd), 32'd0);
        stable_bad = 0;
        for (int k = 0; k < 40; k++) begin
            if (out_valid) stable_bad++;
            step();
        end
        chk("midrst_no_result", 32'(stable_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
